// File: rtl/uart_frame_loader.sv
// Parses a UART byte stream (sync word, slot, PIXELS bytes, checksum) into SDRAM
// frame-buffer write strobes and per-slot validity/error status.
module uart_frame_loader #(
    parameter int unsigned PIXELS      = 307200,
    parameter int unsigned NUM_SLOTS   = 5,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter logic [7:0]  SYNC0       = 8'hA5,
    parameter logic [7:0]  SYNC1       = 8'h5A
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_flag,
    output logic [15:0]          wr_data,
    output logic                 wr_en,
    output logic [22:0]          wr_addr,
    output logic                 wr_load,
    output logic [22:0]          wr_base,
    output logic                 busy,
    output logic                 frame_done,
    output logic [NUM_SLOTS-1:0] frame_valid,
    output logic                 chk_err,
    output logic                 slot_err,
    output logic                 timeout_err
);

    localparam int unsigned CntW  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int unsigned TmoW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned SlotW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [CntW-1:0] LastPix = CntW'(PIXELS - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {StIdle, StSync, StSlot, StPix, StChk} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [TmoW-1:0]        tmo_q, tmo_d;
    logic [7:0]             csum_q, csum_d;
    logic [SlotW-1:0]       slot_q, slot_d;
    logic [22:0]            base_q, base_d;
    logic [22:0]            addr_q, addr_d;
    logic [15:0]            data_q, data_d;
    logic [NUM_SLOTS-1:0]   valid_q, valid_d;
    logic                   en_q, en_d;
    logic                   load_q, load_d;
    logic                   done_q, done_d;
    logic                   chk_err_q, chk_err_d;
    logic                   slot_err_q, slot_err_d;
    logic                   tmo_err_q, tmo_err_d;
    logic                   rx_flag_q;
    logic                   rx_ok;

    // A strobe directly following another is dropped so state is never double-stepped.
    assign rx_ok = rx_flag & ~rx_flag_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        slot_d     = slot_q;
        base_d     = base_q;
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        en_d       = 1'b0;
        load_d     = 1'b0;
        done_d     = 1'b0;
        chk_err_d  = 1'b0;
        slot_err_d = 1'b0;
        tmo_err_d  = 1'b0;
        tmo_d      = (state_q == StIdle || rx_flag) ? '0 : tmo_q + TmoW'(1);

        if (rx_ok) begin
            case (state_q)
                StIdle: begin
                    if (rx_data == SYNC0) state_d = StSync;
                end
                StSync: begin
                    if (rx_data == SYNC1) begin
                        state_d = StSlot;
                    end else if (rx_data != SYNC0) begin
                        state_d = StIdle;
                    end
                end
                StSlot: begin
                    if (32'(rx_data) < NUM_SLOTS) begin
                        slot_d = SlotW'(rx_data);
                        base_d = 23'(rx_data) * 23'(PIXELS);
                        load_d = 1'b1;
                        cnt_d  = '0;
                        csum_d = '0;
                        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                            if (32'(rx_data) == i) valid_d[i] = 1'b0;
                        end
                        state_d = StPix;
                    end else begin
                        slot_err_d = 1'b1;
                        state_d    = StIdle;
                    end
                end
                StPix: begin
                    en_d   = 1'b1;
                    data_d = {8'h00, rx_data};
                    addr_d = base_q + 23'(cnt_q);
                    cnt_d  = cnt_q + CntW'(1);
                    csum_d = csum_q + rx_data;
                    if (cnt_q == LastPix) state_d = StChk;
                end
                StChk: begin
                    done_d = 1'b1;
                    if (rx_data == csum_q) begin
                        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                            if (32'(slot_q) == i) valid_d[i] = 1'b1;
                        end
                    end else begin
                        chk_err_d = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (!rx_flag && state_q != StIdle && tmo_q == TmoLast) begin
            tmo_err_d = 1'b1;
            tmo_d     = '0;
            state_d   = StIdle;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            tmo_q      <= '0;
            csum_q     <= '0;
            slot_q     <= '0;
            base_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            valid_q    <= '0;
            en_q       <= 1'b0;
            load_q     <= 1'b0;
            done_q     <= 1'b0;
            chk_err_q  <= 1'b0;
            slot_err_q <= 1'b0;
            tmo_err_q  <= 1'b0;
            rx_flag_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            csum_q     <= csum_d;
            slot_q     <= slot_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            en_q       <= en_d;
            load_q     <= load_d;
            done_q     <= done_d;
            chk_err_q  <= chk_err_d;
            slot_err_q <= slot_err_d;
            tmo_err_q  <= tmo_err_d;
            rx_flag_q  <= rx_flag;
        end
    end

    assign wr_data     = data_q;
    assign wr_en       = en_q;
    assign wr_addr     = addr_q;
    assign wr_load     = load_q;
    assign wr_base     = base_q;
    assign busy        = (state_q != StIdle);
    assign frame_done  = done_q;
    assign frame_valid = valid_q;
    assign chk_err     = chk_err_q;
    assign slot_err    = slot_err_q;
    assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader: directed packets plus randomized uploads against a
// packet-level model of expected strobes, addresses and slot status.
module tb_uart_frame_loader;

    localparam int unsigned PIXELS      = 4;
    localparam int unsigned NUM_SLOTS   = 5;
    localparam int unsigned TIMEOUT_CYC = 100;

    logic        sys_clk;
    logic        sys_rst;
    logic [7:0]  rx_data;
    logic        rx_flag;
    logic [15:0] wr_data;
    logic        wr_en;
    logic [22:0] wr_addr;
    logic        wr_load;
    logic [22:0] wr_base;
    logic        busy;
    logic        frame_done;
    logic [4:0]  frame_valid;
    logic        chk_err;
    logic        slot_err;
    logic        timeout_err;

    uart_frame_loader #(
        .PIXELS      (PIXELS),
        .NUM_SLOTS   (NUM_SLOTS),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SYNC0       (8'hA5),
        .SYNC1       (8'h5A)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .rx_data     (rx_data),
        .rx_flag     (rx_flag),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_load     (wr_load),
        .wr_base     (wr_base),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_valid (frame_valid),
        .chk_err     (chk_err),
        .slot_err    (slot_err),
        .timeout_err (timeout_err)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int tests = 0;
    int fails = 0;

    // Model state: last written address/data, current base, slot validity, running sum.
    logic [22:0] m_addr = '0;
    logic [15:0] m_data = '0;
    logic [22:0] m_base = '0;
    logic [4:0]  m_fv   = '0;
    logic [7:0]  m_sum  = '0;
    int          m_slot = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit en, input bit ld, input bit dn,
                              input bit ce, input bit se, input bit te, input bit bz);
        chk({tag, ".wr_en"},       32'(wr_en),       32'(en));
        chk({tag, ".wr_load"},     32'(wr_load),     32'(ld));
        chk({tag, ".frame_done"},  32'(frame_done),  32'(dn));
        chk({tag, ".chk_err"},     32'(chk_err),     32'(ce));
        chk({tag, ".slot_err"},    32'(slot_err),    32'(se));
        chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(te));
        chk({tag, ".busy"},        32'(busy),        32'(bz));
        chk({tag, ".wr_addr"},     32'(wr_addr),     32'(m_addr));
        chk({tag, ".wr_data"},     32'(wr_data),     32'(m_data));
        chk({tag, ".wr_base"},     32'(wr_base),     32'(m_base));
        chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
    endtask

    task automatic idle_check(input string tag, input bit bz, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge sys_clk);
            check_outs(tag, 0, 0, 0, 0, 0, 0, bz);
        end
    endtask

    // Send one byte, check the cycle after it is sampled, then idle for gap cycles.
    task automatic step(input string tag, input logic [7:0] b, input bit en, input bit ld,
                        input bit dn, input bit ce, input bit se, input bit bz, input int gap);
        @(negedge sys_clk);
        rx_data = b;
        rx_flag = 1'b1;
        @(negedge sys_clk);
        rx_flag = 1'b0;
        check_outs(tag, en, ld, dn, ce, se, 0, bz);
        idle_check({tag, ".gap"}, bz, gap);
    endtask

    task automatic open_packet(input int s, input int gap);
        step("sync0", 8'hA5, 0, 0, 0, 0, 0, 1, gap);
        step("sync1", 8'h5A, 0, 0, 0, 0, 0, 1, gap);
        if (s >= int'(NUM_SLOTS)) begin
            step("badslot", 8'(s), 0, 0, 0, 0, 1, 0, gap);
        end else begin
            m_base    = 23'(s * int'(PIXELS));
            m_fv[s]   = 1'b0;
            m_sum     = '0;
            m_slot    = s;
            step("slot", 8'(s), 0, 1, 0, 0, 0, 1, gap);
        end
    endtask

    task automatic pix_step(input int i, input logic [7:0] b, input int gap);
        m_addr = m_base + 23'(i);
        m_data = {8'h00, b};
        m_sum  = m_sum + b;
        step("pix", b, 1, 0, 0, 0, 0, 1, gap);
    endtask

    task automatic close_packet(input bit good, input logic [7:0] off, input int gap);
        logic [7:0] cs;
        cs = good ? m_sum : m_sum + off;
        m_fv[m_slot] = good;
        step("chk", cs, 0, 0, 1, !good, 0, 0, gap);
    endtask

    function automatic logic [7:0] rand_pix();
        int r;
        r = $urandom_range(0, 5);
        if (r == 0) return 8'hA5;
        if (r == 1) return 8'h5A;
        return 8'($urandom);
    endfunction

    logic [7:0] tv [4];
    int s;
    int g;
    logic [7:0] nb;

    initial begin
        sys_rst = 1'b1;
        rx_flag = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge sys_clk);
        check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
        sys_rst = 1'b0;
        idle_check("post_reset", 0, 2);

        // Slot 0 good, then the reference packet to slot 2
        open_packet(0, 1);
        for (int i = 0; i < 4; i++) pix_step(i, 8'(i * 3 + 1), 1);
        close_packet(1, 8'h01, 1);
        tv[0] = 8'h10; tv[1] = 8'h20; tv[2] = 8'h30; tv[3] = 8'h40;
        open_packet(2, 0);
        for (int i = 0; i < 4; i++) pix_step(i, tv[i], 0);
        close_packet(1, 8'h01, 2);
        chk("ref.valid", 32'(frame_valid), 32'(5'b00101));

        // Same packet, checksum byte 0x00 (sum is 0xA0)
        open_packet(2, 0);
        for (int i = 0; i < 4; i++) pix_step(i, tv[i], 0);
        close_packet(0, 8'h60, 1);
        chk("badsum.valid", 32'(frame_valid), 32'(5'b00001));

        // Repeated A5, then out-of-range slot, then a good slot-0 upload
        step("rep_a5", 8'hA5, 0, 0, 0, 0, 0, 1, 0);
        open_packet(7, 1);
        open_packet(0, 0);
        for (int i = 0; i < 4; i++) pix_step(i, 8'($urandom), 0);
        close_packet(1, 8'h01, 1);

        // Timeout after 2 pixels: error exactly TIMEOUT_CYC cycles after the last byte
        open_packet(2, 0);
        pix_step(0, 8'h11, 0);
        pix_step(1, 8'h22, 0);
        idle_check("tmo_wait", 1, TIMEOUT_CYC - 1);
        @(negedge sys_clk);
        check_outs("tmo_fire", 0, 0, 0, 0, 0, 1, 0);
        idle_check("tmo_after", 0, 2);
        open_packet(3, 0);
        pix_step(0, 8'h44, TIMEOUT_CYC - 2);
        pix_step(1, 8'h55, 0);
        pix_step(2, 8'h66, 0);
        pix_step(3, 8'h77, 0);
        close_packet(1, 8'h01, 1);

        // Pixel data containing the sync word, plus a dropped back-to-back strobe
        open_packet(4, 0);
        @(negedge sys_clk);
        rx_data = 8'hA5;
        rx_flag = 1'b1;
        m_addr  = m_base;
        m_data  = 16'h00A5;
        m_sum   = 8'hA5;
        @(negedge sys_clk);
        rx_data = 8'h99;
        check_outs("b2b.first", 1, 0, 0, 0, 0, 0, 1);
        @(negedge sys_clk);
        rx_flag = 1'b0;
        check_outs("b2b.drop", 0, 0, 0, 0, 0, 0, 1);
        pix_step(1, 8'h5A, 0);
        pix_step(2, 8'hA5, 0);
        pix_step(3, 8'h5A, 0);
        close_packet(1, 8'h01, 1);

        // Reset in the middle of pixel data
        open_packet(1, 0);
        pix_step(0, 8'h12, 0);
        pix_step(1, 8'h34, 0);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        m_addr = '0; m_data = '0; m_base = '0; m_fv = '0;
        check_outs("midrst", 0, 0, 0, 0, 0, 0, 0);
        step("midrst.stray", 8'h56, 0, 0, 0, 0, 0, 0, 1);
        open_packet(1, 0);
        for (int i = 0; i < 4; i++) pix_step(i, 8'($urandom), 0);
        close_packet(1, 8'h01, 1);

        // Randomized uploads with noise and aborted syncs
        for (int n = 0; n < 24; n++) begin
            s = $urandom_range(0, 6);
            g = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) begin
                nb = 8'($urandom);
                if (nb == 8'hA5) nb = 8'h00;
                step("noise", nb, 0, 0, 0, 0, 0, 0, g);
            end
            if ($urandom_range(0, 4) == 0) begin
                step("abort.a5", 8'hA5, 0, 0, 0, 0, 0, 1, g);
                step("abort.x", 8'h3C, 0, 0, 0, 0, 0, 0, g);
            end
            open_packet(s, g);
            if (s < int'(NUM_SLOTS)) begin
                for (int i = 0; i < int'(PIXELS); i++) pix_step(i, rand_pix(), g);
                close_packet($urandom_range(0, 3) != 0, 8'($urandom_range(1, 255)), g);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
